// File: rtl/add_settle_ctrl.sv
// add_settle_ctrl: launches operand sets onto a slow adder, waits a fixed settle time,
// then captures and holds sum/carry until the downstream handshake completes.
module add_settle_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] LOAD = CW'(SETTLE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic accept, capture;
    // HOLD can hand off its result and take new operands on the same edge
    assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
    assign accept   = in_valid && in_ready;
    assign capture  = (state == SETTLE) && (cnt == '0);
    assign busy     = state != IDLE;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (accept) begin
            state_nx = SETTLE;
            cnt_nx   = LOAD;
        end else if (capture) begin
            state_nx = HOLD;
        end else if (state == SETTLE) begin
            cnt_nx = cnt - 1'b1;
        end else if (state == HOLD && out_ready) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_valid <= state_nx == HOLD;
            if (accept) begin
                op_a   <= a;
                op_b   <= b;
                op_cin <= cin;
            end
            if (capture) begin
                sum  <= add_sum;
                cout <= add_cout;
            end
        end
    end
endmodule

// File: doc/add_settle_ctrl.md
Name: add_settle_ctrl

Overview:
Sequencing stage wrapped around the gate-level ripple/CLA adder array. It accepts an operand set over a valid/ready handshake and registers the operands onto the adder inputs. It then waits a fixed number of clock cycles for the adder's delay-annotated gates to settle, captures sum and carry-out, and presents them downstream over a valid/ready handshake. It sits directly upstream of the adder, which consumes op_a/op_b/op_cin, and directly downstream of it, since it captures add_sum/add_cout.

Parameters:
WIDTH, 4, operand and sum width in bits (>=1)
SETTLE_CYCLES, 6, clock cycles from operand launch to result capture (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operand set valid
in_ready  output  1  block can accept an operand set
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
op_a  output  WIDTH  registered operand A to adder
op_b  output  WIDTH  registered operand B to adder
op_cin  output  1  registered carry-in to adder
add_sum  input  WIDTH  adder sum (combinational, delayed)
add_cout  input  1  adder carry-out
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  captured sum
cout  output  1  captured carry-out
busy  output  1  high in SETTLE or HOLD

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-operation):
  - State goes to IDLE.
  - op_a, op_b, op_cin, sum, cout and the counter clear to 0.
  - out_valid=0, busy=0.
  - In-flight work is discarded.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1, register a/b/cin into op_a/op_b/op_cin, load the counter with SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE:
  - in_ready=0; in_valid and the a/b/cin inputs are ignored.
  - The op_* outputs stay stable.
  - Each edge with counter!=0 decrements the counter.
  - On the edge with counter==0, capture add_sum->sum and add_cout->cout, set out_valid=1, and go to HOLD.
- Latency: if an operand set is accepted at edge N, sum/cout/out_valid update at edge N+SETTLE_CYCLES. With SETTLE_CYCLES=1, capture happens at the edge after acceptance.
- HOLD:
  - out_valid=1; sum and cout are stable until the handshake completes.
  - in_ready = out_ready (combinational).
  - Edge with out_ready=1 and in_valid=0: out_valid->0, go to IDLE.
  - Edge with out_ready=1 and in_valid=1: the result is consumed and the new operands are accepted on the same edge. out_valid->0, the op_* registers load, the counter reloads, and the state goes to SETTLE. This gives back-to-back throughput of one result per SETTLE_CYCLES+1 cycles.
  - Edge with out_ready=0: hold everything. New operands are not accepted.
- Outputs:
  - sum and cout change only on a capture edge; they never track add_sum/add_cout at any other time.
  - busy = (state != IDLE).
- Arithmetic: this block performs no arithmetic. The result width is WIDTH, and overflow is reported only through cout.
- Counter width: clog2(SETTLE_CYCLES)+1 bits; it never wraps below 0.

Test Plan:
- WIDTH=4, SETTLE=6, 20ns clock. Present a=4'hF, b=4'h1, cin=0 at edge 0 with out_ready=1 -> op_a=F/op_b=1 after edge 0; out_valid rises at edge 6 with sum=4'h0, cout=1; out_valid=0 in every earlier cycle.
- Present a=4'h7, b=4'h8, cin=1 -> sum=4'h0, cout=1. Change a/b to 4'h3 during SETTLE -> no effect on op_a/op_b or on the result; in_ready=0 throughout SETTLE.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> sum/cout/out_valid stable and in_ready=0. Raise out_ready -> out_valid falls on the next edge.
- Back-to-back: in_valid held high with three sets (2+3, 9+9, F+F+cin) and out_ready=1 -> results 5/c0, 2/c1, F/c1 at edges 6, 13, 20.
- Reset: assert rst_n=0 at edge 3 of a SETTLE -> all outputs immediately 0 and state IDLE. After release, a new op 1+1 -> sum=2 six cycles after acceptance.
- SETTLE_CYCLES=1 build: 4+5 accepted at edge 0 -> sum=9, out_valid=1 at edge 1.
